// File: rtl/sensor_cond_pkg.sv
// sensor_cond_pkg: period shift constants and cadence generator state type
package sensor_cond_pkg;

    localparam int SHIFT_REAL = 16;
    localparam int SHIFT_FAST = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BOUNCE,
        ST_HIGH,
        ST_LOW
    } cad_gen_state_t;

    function automatic logic [23:0] cad_period(input logic [7:0] per, input bit fast);
        return 24'(per) << (fast ? SHIFT_FAST : SHIFT_REAL);
    endfunction

endpackage

// File: rtl/cadence_bounce_gen.sv
// cadence_bounce_gen: contact-bounce waveform (clean high, then low/high glitch pairs) with end-of-window flag
module cadence_bounce_gen #(
    parameter int BOUNCE_PULSES = 3,
    parameter int BOUNCE_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    output logic level_o,
    output logic done_o
);

    logic [3:0]  len_q;
    logic        low_q;
    logic [15:0] pulses_q;
    logic        half_end;

    assign half_end = len_q == 4'(BOUNCE_LEN - 1);
    assign level_o  = ~low_q;
    assign done_o   = active_i && half_end && !low_q && pulses_q == 16'(BOUNCE_PULSES);

    // counters run only inside the window and sit at zero otherwise, so every window starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            low_q    <= 1'b0;
            pulses_q <= '0;
        end else if (!active_i) begin
            len_q    <= '0;
            low_q    <= 1'b0;
            pulses_q <= '0;
        end else begin
            len_q    <= half_end ? 4'd0 : len_q + 4'd1;
            low_q    <= half_end ? ~low_q : low_q;
            pulses_q <= (half_end && low_q) ? pulses_q + 16'd1 : pulses_q;
        end
    end

endmodule

// File: rtl/cadence_gen.sv
// cadence_gen: square-wave pedal-cadence generator with optional bounce after each rising edge
module cadence_gen
    import sensor_cond_pkg::*;
#(
    parameter int FAST_SIM      = 1,
    parameter int BOUNCE_PULSES = 0,
    parameter int BOUNCE_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] cadence_per,
    output logic       cadence_out,
    output logic       rise_strb,
    output logic [7:0] per_active,
    output logic       busy
);

    localparam int W     = (2 * BOUNCE_PULSES + 1) * BOUNCE_LEN;
    localparam int MIN_H = 1 << ((FAST_SIM != 0 ? SHIFT_FAST : SHIFT_REAL) - 1);
    localparam cad_gen_state_t FIRST = (BOUNCE_PULSES > 0) ? ST_BOUNCE : ST_HIGH;

    if (W >= MIN_H || BOUNCE_LEN < 1 || BOUNCE_LEN > 15) begin : g_bad_cfg
        $error("cadence_gen: bounce window must be shorter than the minimum half period and BOUNCE_LEN in 1..15");
    end

    cad_gen_state_t state_q, state_d;
    logic [23:0]    cnt_q, cnt_d;
    logic [7:0]     per_q, per_d;
    logic [23:0]    period, half;
    logic           start_ok, bounce_level, bounce_done;

    assign period   = cad_period(per_q, FAST_SIM != 0);
    assign half     = period >> 1;
    assign start_ok = en && cadence_per != 8'd0;

    cadence_bounce_gen #(
        .BOUNCE_PULSES(BOUNCE_PULSES),
        .BOUNCE_LEN   (BOUNCE_LEN)
    ) u_bounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .active_i(state_q == ST_BOUNCE),
        .level_o (bounce_level),
        .done_o  (bounce_done)
    );

    // state, period counter and latched period code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
        end
    end

    // next state; a new period code is only taken at start or at the period boundary
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 24'd1;
        per_d   = per_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_ok) begin
                    state_d = FIRST;
                    per_d   = cadence_per;
                end
            end
            ST_BOUNCE: if (bounce_done) state_d = ST_HIGH;
            ST_HIGH:   if (cnt_q == half - 24'd1) state_d = ST_LOW;
            default: begin
                if (cnt_q == period - 24'd1) begin
                    cnt_d   = '0;
                    state_d = start_ok ? FIRST : ST_IDLE;
                    per_d   = start_ok ? cadence_per : 8'd0;
                end
            end
        endcase
    end

    // outputs decoded from state; the rise is the first cycle of a period
    always_comb begin
        cadence_out = state_q == ST_HIGH || (state_q == ST_BOUNCE && bounce_level);
        busy        = state_q != ST_IDLE;
        rise_strb   = busy && cnt_q == 24'd0;
        per_active  = per_q;
    end

endmodule

// File: tb/tb_cadence_gen.sv
// tb_cadence_gen: directed checks of cadence_gen timing, period handover, stop, bounce and reset
module tb_cadence_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en0 = 1'b0, en1 = 1'b0;
    logic [7:0] per0 = 8'd0, per1 = 8'd0;
    logic       out0, rise0, busy0, out1, rise1, busy1;
    logic [7:0] act0, act1;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    cadence_gen #(.FAST_SIM(1), .BOUNCE_PULSES(0), .BOUNCE_LEN(4)) u_clean (
        .clk(clk), .rst_n(rst_n), .en(en0), .cadence_per(per0),
        .cadence_out(out0), .rise_strb(rise0), .per_active(act0), .busy(busy0)
    );

    cadence_gen #(.FAST_SIM(1), .BOUNCE_PULSES(3), .BOUNCE_LEN(4)) u_bounce (
        .clk(clk), .rst_n(rst_n), .en(en1), .cadence_per(per1),
        .cadence_out(out1), .rise_strb(rise1), .per_active(act1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // from a rise cycle, count clocks and high clocks until the next rise
    task automatic meas(output int n, output int hi);
        n = 0;
        hi = 0;
        do begin
            hi += int'(out0);
            @(negedge clk);
            n++;
        end while (!rise0 && n < 5000);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, hi, rises, errs;
        logic exp_lvl;
        #1;
        chk("rst_out", 32'(out0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_act", 32'(act0), 0);
        chk("rst_rise", 32'(rise0), 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        en0 = 1'b1;
        per0 = 8'h04;
        step(1);
        chk("first_rise", 32'(rise0), 1);
        chk("first_out", 32'(out0), 1);
        chk("first_busy", 32'(busy0), 1);
        chk("first_act", 32'(act0), 8'h04);
        meas(n, hi);
        chk("p4_len", 32'(n), 512);
        chk("p4_high", 32'(hi), 256);

        step(100);
        per0 = 8'h08;
        chk("mid_act_hold", 32'(act0), 8'h04);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rise0 && n < 5000);
        chk("p4_rest", 32'(n), 412);
        chk("bound_act", 32'(act0), 8'h08);
        per0 = 8'h02;
        meas(n, hi);
        chk("p8_len", 32'(n), 1024);
        chk("p8_high", 32'(hi), 512);
        chk("p2_act", 32'(act0), 8'h02);

        step(50);
        chk("stop_mid_out", 32'(out0), 1);
        en0 = 1'b0;
        wait_idle(n);
        chk("stop_len", 32'(n), 206);
        chk("stop_out", 32'(out0), 0);
        chk("stop_act", 32'(act0), 0);
        rises = 0;
        repeat (300) begin
            rises += int'(rise0);
            @(negedge clk);
        end
        chk("stop_no_rise", 32'(rises), 0);

        per0 = 8'h00;
        en0 = 1'b1;
        step(20);
        chk("zero_busy", 32'(busy0), 0);
        chk("zero_out", 32'(out0), 0);
        per0 = 8'h01;
        step(1);
        chk("p1_rise", 32'(rise0), 1);
        chk("p1_act", 32'(act0), 8'h01);
        meas(n, hi);
        chk("p1_len", 32'(n), 128);
        chk("p1_high", 32'(hi), 64);
        en0 = 1'b0;
        wait_idle(n);
        chk("p1_stop", 32'(n), 128);

        en1 = 1'b1;
        per1 = 8'h02;
        step(1);
        chk("bnc_rise", 32'(rise1), 1);
        errs = 0;
        rises = 0;
        for (int c = 0; c < 256; c++) begin
            exp_lvl = c < 4 ? 1'b1 : c < 28 ? (((c - 4) / 4) % 2 == 1) : c < 128;
            if (out1 !== exp_lvl) errs++;
            rises += int'(rise1);
            @(negedge clk);
        end
        chk("bnc_wave_errs", 32'(errs), 0);
        chk("bnc_single_rise", 32'(rises), 1);
        chk("bnc_next_rise", 32'(rise1), 1);
        en1 = 1'b0;
        step(300);
        chk("bnc_idle", 32'(busy1), 0);

        per0 = 8'h04;
        en0 = 1'b1;
        step(1);
        chk("rst_run_rise", 32'(rise0), 1);
        step(300);
        chk("rst_mid_out", 32'(out0), 0);
        chk("rst_mid_busy", 32'(busy0), 1);
        en0 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy0), 0);
        chk("arst_act", 32'(act0), 0);
        step(1);
        rst_n = 1'b1;
        rises = 0;
        n = 0;
        repeat (20) begin
            rises += int'(rise0);
            n += int'(out0);
            @(negedge clk);
        end
        chk("post_rst_rise", 32'(rises), 0);
        chk("post_rst_out", 32'(n), 0);

        per0 = 8'h10;
        en0 = 1'b1;
        step(1);
        chk("p16_act", 32'(act0), 8'h10);
        meas(n, hi);
        chk("p16_len_a", 32'(n), 2048);
        meas(n, hi);
        chk("p16_len_b", 32'(n), 2048);
        chk("p16_high", 32'(hi), 1024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
